// File: rtl/cam_arb_pkg.sv
// Shared types and constants for the camera register arbiter.
package cam_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic {
        REQ_S1 = 1'b0,
        REQ_S2 = 1'b1
    } req_id_t;

    localparam int DEF_ADDR_W       = 2;
    localparam int DEF_DATA_W       = 32;
    localparam int MAX_READ_LATENCY = 7;
    localparam int CNT_W            = $clog2(MAX_READ_LATENCY + 1);

endpackage

// File: rtl/camera_reg_arbiter_if.sv
// Bus bundle for the arbiter: two Avalon-MM requester ports and the camera port.
// The slave modport is the arbiter's view; master is the requesters/camera side.
interface camera_reg_arbiter_if
    import cam_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] avs_s1_address;
    logic              avs_s1_read;
    logic              avs_s1_write;
    logic [DATA_W-1:0] avs_s1_writedata;
    logic [DATA_W-1:0] avs_s1_readdata;
    logic              avs_s1_waitrequest;

    logic [ADDR_W-1:0] avs_s2_address;
    logic              avs_s2_read;
    logic              avs_s2_write;
    logic [DATA_W-1:0] avs_s2_writedata;
    logic [DATA_W-1:0] avs_s2_readdata;
    logic              avs_s2_waitrequest;

    logic [ADDR_W-1:0] avm_m1_address;
    logic              avm_m1_read;
    logic              avm_m1_write;
    logic [DATA_W-1:0] avm_m1_writedata;
    logic [DATA_W-1:0] avm_m1_readdata;

    modport slave (
        input  avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
        output avs_s1_readdata, avs_s1_waitrequest,
        input  avs_s2_address, avs_s2_read, avs_s2_write, avs_s2_writedata,
        output avs_s2_readdata, avs_s2_waitrequest,
        output avm_m1_address, avm_m1_read, avm_m1_write, avm_m1_writedata,
        input  avm_m1_readdata
    );

    modport master (
        output avs_s1_address, avs_s1_read, avs_s1_write, avs_s1_writedata,
        input  avs_s1_readdata, avs_s1_waitrequest,
        output avs_s2_address, avs_s2_read, avs_s2_write, avs_s2_writedata,
        input  avs_s2_readdata, avs_s2_waitrequest,
        input  avm_m1_address, avm_m1_read, avm_m1_write, avm_m1_writedata,
        output avm_m1_readdata
    );

endinterface

// File: rtl/cam_arb_rr.sv
// Combinational 2-way grant picker: round-robin by default, fixed s1 priority
// when CAM_ARB_S1_PRIORITY_EN is defined.
module cam_arb_rr
    import cam_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output req_id_t    winner
);

`ifdef CAM_ARB_S1_PRIORITY_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner = REQ_S1;
        if (!req[0] && req[1]) winner = REQ_S2;
    end
`else
    // NOTE: default assigned first so every path drives winner (no latch).
    always_comb begin
        winner = REQ_S1;
        if (req == 2'b10) begin
            winner = REQ_S2;
        end else if (req == 2'b11 && last == REQ_S1) begin
            winner = REQ_S2;
        end
    end
`endif

endmodule

// File: rtl/camera_reg_arbiter.sv
// Serialises two Avalon-MM requesters onto the single camera register port.
// Optional fixed s1 priority via CAM_ARB_S1_PRIORITY_EN (default: round-robin).
module camera_reg_arbiter
    import cam_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input logic                 avs_s1_clk,
    input logic                 avs_s1_reset,
    camera_reg_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] RL_LOAD = CNT_W'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    req_id_t           last_q, id_q, win;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_q, wr_q;
    logic              wait_s1_q, wait_s2_q;
    logic [DATA_W-1:0] rdata_s1_q, rdata_s2_q;

    logic [1:0] req;
    logic       win_wr;

    assign req[0] = bus.avs_s1_read | bus.avs_s1_write;
    assign req[1] = bus.avs_s2_read | bus.avs_s2_write;
    // Write takes precedence when a requester asserts both strobes.
    assign win_wr = (win == REQ_S1) ? bus.avs_s1_write : bus.avs_s2_write;

    cam_arb_rr u_rr (
        .req    (req),
        .last   (last_q),
        .winner (win)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = ISSUE;
            ISSUE:   state_d = op_wr_q ? ACK : WAIT;
            WAIT:    if (cnt_q == '0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge avs_s1_clk or posedge avs_s1_reset) begin
        if (avs_s1_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge avs_s1_clk or posedge avs_s1_reset) begin
        if (avs_s1_reset) begin
            last_q     <= REQ_S2;
            id_q       <= REQ_S1;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wait_s1_q  <= 1'b1;
            wait_s2_q  <= 1'b1;
            rdata_s1_q <= '0;
            rdata_s2_q <= '0;
        end else begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wait_s1_q <= 1'b1;
            wait_s2_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (|req) begin
                        id_q    <= win;
                        op_wr_q <= win_wr;
                        addr_q  <= (win == REQ_S1) ? bus.avs_s1_address   : bus.avs_s2_address;
                        wdata_q <= (win == REQ_S1) ? bus.avs_s1_writedata : bus.avs_s2_writedata;
                        wr_q    <= win_wr;
                        rd_q    <= !win_wr;
                    end
                end
                ISSUE: cnt_q <= RL_LOAD;
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (id_q == REQ_S1) rdata_s1_q <= bus.avm_m1_readdata;
                        else                rdata_s2_q <= bus.avm_m1_readdata;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ACK:     last_q <= id_q;
                default: ;
            endcase

            // Registered ack: waitrequest drops for the single cycle spent in ACK.
            if (state_d == ACK) begin
                if (id_q == REQ_S1) wait_s1_q <= 1'b0;
                else                wait_s2_q <= 1'b0;
            end
        end
    end

    assign bus.avm_m1_address     = addr_q;
    assign bus.avm_m1_writedata   = wdata_q;
    assign bus.avm_m1_read        = rd_q;
    assign bus.avm_m1_write       = wr_q;
    assign bus.avs_s1_waitrequest = wait_s1_q;
    assign bus.avs_s2_waitrequest = wait_s2_q;
    assign bus.avs_s1_readdata    = rdata_s1_q;
    assign bus.avs_s2_readdata    = rdata_s2_q;

endmodule
